// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 4-bit ALU among NREQ clients.
// Registers the granted operation onto the ALU, captures the result and returns it with the requester ID.
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [8*NREQ-1:0] req_sel,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [7:0]        alu_sel,
    input  logic [3:0]        alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_result,
    output logic              rsp_err,
    output logic              busy
);

    // state  | meaning
    // IDLE   | arbitrating; req_ready may assert for the grant winner
    // EXEC   | operands registered on the ALU, result settling
    // RESP   | response held until rsp_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [3:0]     alu_a_q, alu_a_d;
    logic [3:0]     alu_b_q, alu_b_d;
    logic [7:0]     alu_sel_q, alu_sel_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [3:0]     rsp_result_q, rsp_result_d;
    logic           rsp_err_q, rsp_err_d;

    logic [IDW-1:0] grant;
    logic           found;
    logic [3:0]     gnt_a;
    logic [3:0]     gnt_b;
    logic [7:0]     gnt_sel;
    logic           exec_err;

    // Descending scan so the candidate closest to ptr (k = 0) is assigned last and wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (|(req_valid & (NREQ'(1) << ((int'(ptr_q) + k) % NREQ)))) begin
                grant = IDW'((int'(ptr_q) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_a   = '0;
        gnt_b   = '0;
        gnt_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                gnt_a   = req_a[4*i +: 4];
                gnt_b   = req_b[4*i +: 4];
                gnt_sel = req_sel[8*i +: 8];
            end
        end
    end

    assign exec_err = (alu_sel_q > 8'h19) ||
                      (((alu_sel_q == 8'h01) || (alu_sel_q == 8'h04)) && (alu_b_q == 4'd0));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready = NREQ'(1) << grant;
                    alu_a_d   = gnt_a;
                    alu_b_d   = gnt_b;
                    alu_sel_d = gnt_sel;
                    rsp_id_d  = grant;
                    ptr_d     = IDW'((int'(grant) + 1) % NREQ);
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_err_d    = exec_err;
                rsp_result_d = exec_err ? 4'd0 : alu_result;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_sel_q    <= 8'h10;
            rsp_id_q     <= '0;
            rsp_result_q <= 4'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model. Includes a behavioural ALU.
module tb_alu_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [8*NREQ-1:0] req_sel;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [7:0]        alu_sel;
    logic [3:0]        alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_result;
    logic              rsp_err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 00 mul, 01 div, 02 add, 03 sub, 04 mod, 10 and, 11 or, otherwise xor.
    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [7:0] s);
        logic [7:0] p;
        case (s)
            8'h00: begin p = {4'd0, a} * {4'd0, b}; return p[3:0]; end
            8'h01: return (b == 4'd0) ? 4'd0 : a / b;
            8'h02: return a + b;
            8'h03: return a - b;
            8'h04: return (b == 4'd0) ? 4'd0 : a % b;
            8'h10: return a & b;
            8'h11: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_sel);

    function automatic logic ref_err(input logic [3:0] b, input logic [7:0] s);
        return (s > 8'h19) || ((s == 8'h01 || s == 8'h04) && b == 4'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
        chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'h0);
        chk({tag, "_rsp_id"},     32'(rsp_id),     32'h0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 32'h0);
        chk({tag, "_rsp_err"},    32'(rsp_err),    32'h0);
        chk({tag, "_busy"},       32'(busy),       32'h0);
        chk({tag, "_alu_a"},      32'(alu_a),      32'h0);
        chk({tag, "_alu_b"},      32'(alu_b),      32'h0);
        chk({tag, "_alu_sel"},    32'(alu_sel),    32'h10);
    endtask

    task automatic set_one(input int id, input logic [3:0] a, input logic [3:0] b, input logic [7:0] s);
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_sel = 32'($urandom);
        req_a[4*id +: 4]   = a;
        req_b[4*id +: 4]   = b;
        req_sel[8*id +: 8] = s;
        req_valid = NREQ'(1) << id;
    endtask

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] sel;
        logic [3:0] exp_res;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic do_single(input vec_t v);
        @(negedge clk);
        set_one(v.id, v.a, v.b, v.sel);
        rsp_ready = 1'b1;
        #1;
        chk("vec_accept_ready", 32'(req_ready), 32'(NREQ'(1) << v.id));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("vec_exec_busy",  32'(busy),      32'h1);
        chk("vec_exec_rsp_v", 32'(rsp_valid), 32'h0);
        chk("vec_exec_alu_a", 32'(alu_a),     32'(v.a));
        chk("vec_exec_alu_b", 32'(alu_b),     32'(v.b));
        chk("vec_exec_alu_s", 32'(alu_sel),   32'(v.sel));
        @(negedge clk);
        #1;
        chk("vec_rsp_valid",  32'(rsp_valid),  32'h1);
        chk("vec_rsp_id",     32'(rsp_id),     32'(v.id));
        chk("vec_rsp_result", 32'(rsp_result), 32'(v.exp_res));
        chk("vec_rsp_err",    32'(rsp_err),    32'(v.exp_err));
        @(negedge clk);
        #1;
        chk("vec_post_valid", 32'(rsp_valid), 32'h0);
        chk("vec_post_busy",  32'(busy),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcnt;
        int gidx[5];
        int gcyc[5];
        int idx;
        logic [7:0] sel_pool[11];
        int         m_ptr;
        int         m_phase;
        int         m_id;
        logic [3:0] m_a, m_b, m_res;
        logic [7:0] m_sel;
        logic       m_err;

        vecs[0] = '{2, 4'd3,  4'd4, 8'h02, 4'd7,  1'b0};
        vecs[1] = '{0, 4'd9,  4'd0, 8'h01, 4'd0,  1'b1};
        vecs[2] = '{1, 4'd5,  4'd3, 8'h2A, 4'd0,  1'b1};
        vecs[3] = '{3, 4'd9,  4'd4, 8'h04, 4'd1,  1'b0};
        vecs[4] = '{0, 4'd9,  4'd2, 8'h01, 4'd4,  1'b0};
        vecs[5] = '{1, 4'd7,  4'd0, 8'h04, 4'd0,  1'b1};
        vecs[6] = '{2, 4'd6,  4'd3, 8'h19, 4'd5,  1'b0};
        vecs[7] = '{2, 4'd6,  4'd3, 8'h1A, 4'd0,  1'b1};
        vecs[8] = '{1, 4'd12, 4'd0, 8'h02, 4'hC,  1'b0};
        vecs[9] = '{3, 4'd15, 4'd2, 8'h00, 4'hE,  1'b0};

        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sel = '0;
        rsp_ready = 1'b0;
        #23;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during EXEC, then round-robin from requester 0.
        @(negedge clk);
        set_one(2, 4'd1, 4'd1, 8'h02);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("midrst_in_exec", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst_async");
        @(negedge clk);
        #1;
        chk_reset("midrst_next");
        rst_n = 1'b1;
        req_a = 16'h4321;
        req_b = 16'h1111;
        req_sel = 32'h02020202;
        req_valid = '1;
        gcnt = 0;
        for (int c = 0; c < 40 && gcnt < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
                chk("rr_onehot", 32'($countones(req_ready)), 32'h1);
                gidx[gcnt] = idx;
                gcyc[gcnt] = c;
                gcnt++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr_grant_count", 32'(gcnt), 32'd5);
        for (int i = 0; i < gcnt; i++) begin
            chk("rr_grant_order", 32'(gidx[i]), 32'(i % NREQ));
            if (i > 0) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        repeat (4) @(negedge clk);

        // Backpressure: requester 1 served, response held for 5 cycles.
        set_one(1, 4'd5, 4'd6, 8'h02);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '1;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("bp_rsp_valid",  32'(rsp_valid),  32'h1);
            chk("bp_rsp_id",     32'(rsp_id),     32'h1);
            chk("bp_rsp_result", 32'(rsp_result), 32'hB);
            chk("bp_rsp_err",    32'(rsp_err),    32'h0);
            chk("bp_req_ready",  32'(req_ready),  32'h0);
            chk("bp_alu_a",      32'(alu_a),      32'h5);
            chk("bp_busy",       32'(busy),       32'h1);
            if (c == 5) rsp_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        chk("bp_next_accept", 32'(req_ready), 32'h4);
        chk("bp_valid_drop",  32'(rsp_valid), 32'h0);
        req_valid = '0;

        for (int i = 0; i < 10; i++) do_single(vecs[i]);

        // Requester 3 just served, so contention goes to 0.
        req_valid = '1;
        #1;
        chk("wrap_contention", 32'(req_ready), 32'h1);
        req_valid = '0;

        // Randomized run against the reference model.
        sel_pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h19, 8'h1A, 8'h2A, 8'hFF};
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_phase = 0;
        m_id = 0;
        m_a = '0; m_b = '0; m_sel = '0; m_res = '0; m_err = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                req_a[4*i +: 4]   = 4'($urandom);
                req_b[4*i +: 4]   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
                req_sel[8*i +: 8] = sel_pool[$urandom_range(0, 10)];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_phase == 0) begin
                int g;
                g = -1;
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                chk("rnd_idle_ready", 32'(req_ready), (g < 0) ? 32'h0 : 32'(1 << g));
                chk("rnd_idle_busy",  32'(busy),      32'h0);
                chk("rnd_idle_rspv",  32'(rsp_valid), 32'h0);
                if (g >= 0) begin
                    m_id  = g;
                    m_a   = req_a[4*g +: 4];
                    m_b   = req_b[4*g +: 4];
                    m_sel = req_sel[8*g +: 8];
                    m_err = ref_err(m_b, m_sel);
                    m_res = m_err ? 4'd0 : alu_fn(m_a, m_b, m_sel);
                    m_ptr = (g + 1) % NREQ;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                chk("rnd_exec_ready", 32'(req_ready), 32'h0);
                chk("rnd_exec_busy",  32'(busy),      32'h1);
                chk("rnd_exec_rspv",  32'(rsp_valid), 32'h0);
                chk("rnd_exec_alu",   {12'd0, alu_a, alu_b, alu_sel}, {12'd0, m_a, m_b, m_sel});
                m_phase = 2;
            end else begin
                chk("rnd_rsp_ready",  32'(req_ready),  32'h0);
                chk("rnd_rsp_busy",   32'(busy),       32'h1);
                chk("rnd_rsp_valid",  32'(rsp_valid),  32'h1);
                chk("rnd_rsp_id",     32'(rsp_id),     32'(m_id));
                chk("rnd_rsp_result", 32'(rsp_result), 32'(m_res));
                chk("rnd_rsp_err",    32'(rsp_err),    32'(m_err));
                if (rsp_ready) m_phase = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 4-bit ALU among `NREQ` requesters. It accepts one operation at a time through a valid/ready handshake and drives registered operands and opcode onto the ALU. It then captures the ALU result and returns it with the requester ID, also through a valid/ready handshake. It sits between client blocks and the ALU instance, and it screens out illegal opcodes and divide/modulo by zero before they reach the response.

## Interface
- `NREQ`, default 4, number of requesters (2..8).
- `IDW`, default 2, width of requester ID; must equal clog2(`NREQ`).
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  NREQ  per-requester request valid.
- `req_ready`  output  NREQ  per-requester accept; one-hot or zero.
- `req_a`  input  4*NREQ  operand A; requester i occupies bits [4i+3:4i].
- `req_b`  input  4*NREQ  operand B, same packing as `req_a`.
- `req_sel`  input  8*NREQ  ALU opcode; requester i occupies bits [8i+7:8i].
- `alu_a`  output  4  registered operand A to the ALU.
- `alu_b`  output  4  registered operand B to the ALU.
- `alu_sel`  output  8  registered opcode to the ALU.
- `alu_result`  input  4  combinational result from the ALU.
- `rsp_valid`  output  1  response valid.
- `rsp_ready`  input  1  response consumer ready.
- `rsp_id`  output  IDW  index of the requester that issued the operation.
- `rsp_result`  output  4  result; 0 when `rsp_err`=1.
- `rsp_err`  output  1  illegal opcode, or divide/modulo by zero.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset enters IDLE.
- **IDLE**
  - The grant `g` is the first index i with `req_valid[i]`=1, searching from `ptr` upward and wrapping modulo `NREQ`.
  - `req_ready[g]`=1 combinationally; all other `req_ready` bits are 0. With no valid request, `req_ready`=0.
  - On acceptance, latch `req_a`/`req_b`/`req_sel` slice g into `alu_a`/`alu_b`/`alu_sel`, latch `rsp_id`=g, set `ptr`=(g+1) mod NREQ, and go to EXEC.
- **EXEC** (exactly one cycle)
  - `alu_*` are stable and the ALU settles.
  - At the end of the cycle, compute `err` = (`alu_sel` > 8'h19) OR ((`alu_sel`==8'h01 OR `alu_sel`==8'h04) AND `alu_b`==0).
  - Capture `rsp_err`=err and `rsp_result` = err ? 0 : `alu_result`. Go to RESP.
- **RESP**
  - `rsp_valid`=1, with `rsp_id`/`rsp_result`/`rsp_err` held stable until `rsp_ready`=1.
  - On `rsp_valid`&&`rsp_ready`, go to IDLE; `rsp_valid` drops next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- `req_ready` is 0 in EXEC and RESP regardless of `req_valid`.
- `alu_a`/`alu_b`/`alu_sel` hold their last issued values outside EXEC.
- A requester that drops `req_valid` before it is granted loses nothing. Once accepted, its operands are owned by the arbiter.
- **Reset mid-operation:** `rst_n` low in any state immediately forces IDLE. The pending response is discarded.
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0, `busy`=0.
  - `alu_a`=0, `alu_b`=0, `alu_sel`=8'h10 (AND, a legal opcode); `ptr`=0.

## Timing
- Accept in cycle T (IDLE, `req_valid[g]`&&`req_ready[g]`). EXEC is cycle T+1. `rsp_valid` rises at T+2.
- Minimum turnaround is 3 cycles per operation (accept, EXEC, RESP with `rsp_ready`=1); the next accept is at T+3.
- Backpressure stretches RESP indefinitely; every output stays frozen meanwhile.
- All outputs are registered except `req_ready`, which is combinational from the state, `ptr` and `req_valid`.
- `busy` is high for cycles T+1 through the RESP handshake cycle inclusive.

## Test plan
- **Single request:** requester 2 sends a=3, b=4, sel=8'h02 -> `req_ready[2]` in the accept cycle, then `rsp_valid` 2 cycles later with `rsp_id`=2, `rsp_result`=7, `rsp_err`=0.
- **Round-robin:** all 4 requesters hold `req_valid`=1 with `rsp_ready`=1 -> grants in order 0,1,2,3,0 on accepts spaced 3 cycles apart.
- **Error cases:** sel=8'h01, b=0 -> `rsp_err`=1, `rsp_result`=0. sel=8'h2A -> `rsp_err`=1, `rsp_result`=0. sel=8'h04, a=9, b=4 -> result 1, `rsp_err`=0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP -> `rsp_*` stable, `req_ready`=0 throughout. The next accept comes one cycle after the handshake.
- **Reset mid-operation:** assert `rst_n`=0 during EXEC -> next cycle all outputs are at reset values and `ptr`=0. After release, requester 0 wins first.
- **Wrap and arithmetic overflow:** requester 3 sends a=15, b=2, sel=8'h00 -> `rsp_result`=4'hE (truncated). The following contention is granted to requester 0.
